// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR command path: FSM state, default
// timing constants, and the two-bit {S,R} command code used by the SR stages.
package sr_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sr_state_e;

  localparam int unsigned DEBOUNCE_DEF = 4;
  localparam int unsigned HOLDOFF_DEF  = 3;

  // Bit 1 is S, bit 0 is R; CMD_BOTH is the illegal combination and is only
  // ever used internally to flag a conflict, never driven onto s/r.
  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_RST  = 2'b01,
    CMD_SET  = 2'b10,
    CMD_BOTH = 2'b11
  } sr_cmd_e;

endpackage

// File: rtl/sr_debounce_ch.sv
// One request channel: 2-flop synchroniser, debounce counter and accepted
// level, plus a strobe on the cycle a 0->1 level change is accepted.
module sr_debounce_ch #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CW       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic lvl_o,
  output logic rise_o
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          sy;
  logic          accept;

  assign sy = sync_q[1];

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d  = '0;
    lvl_d  = lvl_q;
    accept = 1'b0;
    if (sy != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d  = sy;
        accept = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = accept & sy;

endmodule

// File: rtl/sr_cmd_debouncer.sv
// Command front end for the SR flop: debounces set/clear requests and issues
// single-cycle, mutually exclusive s/r pulses separated by a hold-off window.
module sr_cmd_debouncer
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEF,
  parameter int unsigned HOLDOFF  = HOLDOFF_DEF,
  parameter int unsigned CW       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic set_in,
  input  logic clr_in,
  output logic s,
  output logic r,
  output logic conflict,
  output logic set_lvl,
  output logic clr_lvl,
  output logic busy
);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF - 1);

  logic          ev_s, ev_r;
  logic          req_s, req_r;
  sr_state_e     state_q, state_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          pend_s_q, pend_s_d;
  logic          pend_r_q, pend_r_d;
  sr_cmd_e       cmd_q, cmd_d;

  sr_debounce_ch #(.DEBOUNCE(DEBOUNCE), .CW(CW)) u_set_ch (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (set_in),
    .lvl_o  (set_lvl),
    .rise_o (ev_s)
  );

  sr_debounce_ch #(.DEBOUNCE(DEBOUNCE), .CW(CW)) u_clr_ch (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (clr_in),
    .lvl_o  (clr_lvl),
    .rise_o (ev_r)
  );

  assign req_s = ev_s | pend_s_q;
  assign req_r = ev_r | pend_r_q;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    pend_s_d = pend_s_q;
    pend_r_d = pend_r_q;
    cmd_d    = CMD_NONE;
    unique case (state_q)
      IDLE: begin
        if (req_s | req_r) begin
          // Both requests at once map onto CMD_BOTH, which decodes to conflict.
          cmd_d    = sr_cmd_e'({req_s, req_r});
          pend_s_d = 1'b0;
          pend_r_d = 1'b0;
          hold_d   = '0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        pend_s_d = pend_s_q | ev_s;
        pend_r_d = pend_r_q | ev_r;
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every control register is cleared by the asynchronous reset; this
  // block holds no storage arrays, so nothing is left uninitialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      pend_s_q <= 1'b0;
      pend_r_q <= 1'b0;
      cmd_q    <= CMD_NONE;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      pend_s_q <= pend_s_d;
      pend_r_q <= pend_r_d;
      cmd_q    <= cmd_d;
    end
  end

  assign s        = (cmd_q == CMD_SET);
  assign r        = (cmd_q == CMD_RST);
  assign conflict = (cmd_q == CMD_BOTH);
  assign busy     = (state_q == HOLD);

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Directed bench for sr_cmd_debouncer (DEBOUNCE=4, HOLDOFF=3), plus a second
// instance with a long hold-off so both channels can queue during one HOLD.
module tb_sr_cmd_debouncer;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic set_in = 1'b0;
  logic clr_in = 1'b0;
  logic set2   = 1'b0;
  logic clr2   = 1'b0;

  logic s, r, conflict, set_lvl, clr_lvl, busy;
  logic s2, r2, conflict2, set_lvl2, clr_lvl2, busy2;

  int n_assert = 0;
  int n_fail   = 0;

  sr_cmd_debouncer #(.DEBOUNCE(4), .HOLDOFF(3), .CW(8)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .set_in   (set_in),
    .clr_in   (clr_in),
    .s        (s),
    .r        (r),
    .conflict (conflict),
    .set_lvl  (set_lvl),
    .clr_lvl  (clr_lvl),
    .busy     (busy)
  );

  sr_cmd_debouncer #(.DEBOUNCE(4), .HOLDOFF(12), .CW(8)) u_dut_long (
    .clk      (clk),
    .rst      (rst),
    .set_in   (set2),
    .clr_in   (clr2),
    .s        (s2),
    .r        (r2),
    .conflict (conflict2),
    .set_lvl  (set_lvl2),
    .clr_lvl  (clr_lvl2),
    .busy     (busy2)
  );

  initial forever #5 clk = ~clk;

  // Output bundle order: {s, r, conflict, set_lvl, clr_lvl, busy}
  function automatic logic [5:0] outs();
    return {s, r, conflict, set_lvl, clr_lvl, busy};
  endfunction

  function automatic logic [5:0] outs2();
    return {s2, r2, conflict2, set_lvl2, clr_lvl2, busy2};
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [5:0] exp);
    tick();
    check(tag, outs(), exp);
  endtask

  task automatic settle(input string tag);
    set_in = 1'b0;
    clr_in = 1'b0;
    set2   = 1'b0;
    clr2   = 1'b0;
    repeat (16) tick();
    check({tag, "_a"}, outs(), 6'b000000);
    check({tag, "_b"}, outs2(), 6'b000000);
  endtask

  // s, r and conflict must be mutually exclusive on every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("exclusive", {4'b0000,
                          (s & r) | (s & conflict) | (r & conflict),
                          (s2 & r2) | (s2 & conflict2) | (r2 & conflict2)},
            6'b000000);
    end
  end

  initial begin
    logic [5:0] exp;

    // Reset state
    #2 rst = 1'b1;
    #1 check("reset_async", outs(), 6'b000000);
    check("reset_async2", outs2(), 6'b000000);
    tick();
    tick();
    check("reset_held", outs(), 6'b000000);
    rst = 1'b0;
    step("post_reset", 6'b000000);

    // Clean set: s and set_lvl on edge 6, then 3 busy cycles
    set_in = 1'b1;
    for (int e = 1; e <= 5; e++) step($sformatf("clean_e%0d", e), 6'b000000);
    step("clean_e6", 6'b100101);
    step("clean_e7", 6'b000101);
    step("clean_e8", 6'b000101);
    step("clean_e9", 6'b000100);
    settle("clean_settle");

    // Bounce on clr: 1,0,1,0 then stable high
    clr_in = 1'b1; step("bnc_b1", 6'b000000);
    clr_in = 1'b0; step("bnc_b2", 6'b000000);
    clr_in = 1'b1; step("bnc_b3", 6'b000000);
    clr_in = 1'b0; step("bnc_b4", 6'b000000);
    clr_in = 1'b1;
    for (int e = 1; e <= 5; e++) step($sformatf("bnc_e%0d", e), 6'b000000);
    step("bnc_e6", 6'b010011);
    step("bnc_e7", 6'b000011);
    step("bnc_e8", 6'b000011);
    step("bnc_e9", 6'b000010);
    settle("bnc_settle");

    // Simultaneous rise: conflict only
    set_in = 1'b1;
    clr_in = 1'b1;
    for (int e = 1; e <= 5; e++) step($sformatf("sim_e%0d", e), 6'b000000);
    step("sim_e6", 6'b001111);
    step("sim_e7", 6'b000111);
    step("sim_e8", 6'b000111);
    step("sim_e9", 6'b000110);
    settle("sim_settle");

    // Queueing: clr event one cycle after s, serviced on first IDLE cycle
    set_in = 1'b1;
    step("q_e1", 6'b000000);
    clr_in = 1'b1;
    for (int e = 2; e <= 5; e++) step($sformatf("q_e%0d", e), 6'b000000);
    step("q_e6", 6'b100101);
    step("q_e7", 6'b000111);
    step("q_e8", 6'b000111);
    step("q_e9", 6'b000110);
    step("q_e10", 6'b010111);
    step("q_e11", 6'b000111);
    step("q_e12", 6'b000111);
    step("q_e13", 6'b000110);
    settle("q_settle");

    // Glitch: three sampled high cycles are not enough
    set_in = 1'b1;
    for (int e = 1; e <= 3; e++) step($sformatf("gl_e%0d", e), 6'b000000);
    set_in = 1'b0;
    for (int e = 4; e <= 10; e++) step($sformatf("gl_e%0d", e), 6'b000000);

    // Long hold-off instance: s at 6, clr event at 10 and a second set event
    // at 16 both queue during HOLD (edges 6..17), conflict at edge 19.
    set2 = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      if (e == 5)  clr2 = 1'b1;
      if (e == 7)  set2 = 1'b0;
      if (e == 11) set2 = 1'b1;
      tick();
      exp = {(e == 6), 1'b0, (e == 19),
             ((e >= 6 && e <= 11) || e >= 16),
             (e >= 10),
             ((e >= 6 && e <= 17) || e >= 19)};
      check($sformatf("long_e%0d", e), outs2(), exp);
    end
    settle("long_settle");

    // Reset during HOLD with clr pending; set_in still high afterwards
    set_in = 1'b1;
    step("rm_e1", 6'b000000);
    clr_in = 1'b1;
    for (int e = 2; e <= 5; e++) step($sformatf("rm_e%0d", e), 6'b000000);
    step("rm_e6", 6'b100101);
    step("rm_e7", 6'b000111);
    rst = 1'b1;
    #1 check("rm_async", outs(), 6'b000000);
    clr_in = 1'b0;
    tick();
    tick();
    check("rm_held", outs(), 6'b000000);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) step($sformatf("rm_r%0d", e), 6'b000000);
    step("rm_r6", 6'b100101);
    step("rm_r7", 6'b000101);
    step("rm_r8", 6'b000101);
    for (int e = 9; e <= 12; e++) step($sformatf("rm_r%0d", e), 6'b000100);
    settle("rm_settle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_cmd_debouncer.md
Name: sr_cmd_debouncer

Overview:
- Upstream command stage for the SR-behaviour flip-flop (the JK-to-SR converted cell).
- Takes two raw, asynchronous, bouncy request lines (set request, clear request).
- Synchronises and debounces both lines, then turns each debounced rising edge into a single-cycle s or r pulse.
- Guarantees s and r are never high together, and enforces a minimum spacing between commands so the downstream flop only sees clean, legal SR inputs.

Parameters:
- DEBOUNCE, 4: consecutive synchronised cycles a new input level must hold before it is accepted; legal range 1..255.
- HOLDOFF, 3: cycles spent in HOLD after any emitted command or conflict; legal range 1..255.
- CW, 8: width of the debounce and hold-off counters; must satisfy 2^CW > max(DEBOUNCE, HOLDOFF).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- set_in  in  1  raw set request, asynchronous to clk.
- clr_in  in  1  raw clear request, asynchronous to clk.
- s  out  1  one-cycle set command to the SR stage.
- r  out  1  one-cycle reset command to the SR stage.
- conflict  out  1  one-cycle flag: set and clear became due in the same cycle, so both were discarded.
- set_lvl  out  1  debounced level of set_in.
- clr_lvl  out  1  debounced level of clr_in.
- busy  out  1  high while the FSM is in HOLD.

Behaviour:
- Reset: while rst=1, all of the following are 0 immediately (asynchronous): s, r, conflict, set_lvl, clr_lvl, busy, both synchroniser flops, both counters, both pending bits. FSM is forced to IDLE.
- Synchroniser: each input passes through a 2-flop synchroniser. The sync output is called sy.
- Debounce, per channel:
  - sy==lvl: counter cleared.
  - sy!=lvl: counter increments.
  - When the counter equals DEBOUNCE-1 while sy!=lvl, lvl<=sy and the counter clears.
  - A glitch shorter than DEBOUNCE synchronised cycles is never accepted.
  - An accepted 0->1 change is an event, evaluated in the same cycle. Accepted 1->0 changes produce no event.
- Latency: counting the first edge that samples set_in=1 as edge 1, set_lvl rises and s is registered high on edge DEBOUNCE+2. s stays high for exactly one cycle. The clear path has identical latency.
- FSM states:
  - IDLE:
    - req_s = ev_s | pend_s and req_r = ev_r | pend_r.
    - Exactly one request: emit s or r for one cycle, clear both pending bits, go to HOLD with the hold counter at 0.
    - Both requests: emit conflict only (s=r=0), clear both pending bits, go to HOLD.
    - No request: stay in IDLE.
  - HOLD:
    - busy=1; s, r and conflict are 0 after the first cycle.
    - An event on a channel sets that channel's pending bit. Repeated events on the same channel merge into one.
    - The hold counter increments each cycle. On reaching HOLDOFF-1 the FSM returns to IDLE.
    - Pending bits are serviced on the first IDLE cycle, following the IDLE rules above, including conflict when both are pending.
  - Encoding: IDLE=0, HOLD=1.
- Invariants:
  - s & r is never 1.
  - At most one of s, r, conflict is high in any cycle.
  - Consecutive commands are at least HOLDOFF+1 cycles apart.
- Reset mid-operation: pending bits, counters and any in-flight pulse are lost. If an input is still high after rst releases, it is debounced again and produces one fresh event.
- An input held high indefinitely produces exactly one event.

Decomposition:
- Shared package sr_ctrl_pkg holds:
  - the FSM state typedef (IDLE, HOLD);
  - the default constants DEBOUNCE_DEF=4 and HOLDOFF_DEF=3;
  - the command-code constants used by other SR stages.
- One sub-module, sr_debounce_ch, instantiated twice:
  - contains the synchroniser, the debounce counter and the level register;
  - outputs lvl and the rising-event strobe.
- The FSM and arbitration live in the top level.

Test Plan (DEBOUNCE=4, HOLDOFF=3):
- Clean set: set_in rises and stays high; first sampling edge = 1 -> set_lvl=1 and s=1 on edge 6 only. r=0 and conflict=0 throughout; busy=1 for the next 3 cycles.
- Bounce: clr_in toggles 1,0,1,0,1 on alternate cycles, then holds high -> exactly one r pulse, on edge 6 counted from the start of the final stable high. No earlier pulse.
- Simultaneous: set_in and clr_in rise on the same cycle -> conflict=1 for one cycle; s=0 and r=0; busy follows for 3 cycles.
- Hold-off queueing:
  - set accepted at cycle T gives s at T.
  - clr event arrives at T+1 -> r=1 at T+4 (first IDLE cycle), not earlier.
  - set and clr events both arrive during HOLD -> conflict on the first IDLE cycle instead of a command.
- Reset mid-operation: assert rst during HOLD with clr pending -> all outputs 0 immediately and the pending clr is lost. Release rst with set_in held high -> s pulse on edge 6 after release.
- Glitch rejection: set_in high for 3 synchronised cycles, then low -> set_lvl stays 0 and no s pulse.
